// File: rtl/sub_16_bit_seq_pkg.sv
// Shared definitions for the sequential 16-bit subtractor: data width,
// FSM state encoding and slice-counter width.
package sub_pkg;

    localparam int DATA_W = 16;
    // Wide enough to count up to 16 slices (SLICE_W = 1).
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow of a - b: the operand signs differ and
    // the result sign differs from the minuend sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/sub_16_bit_seq_slice.sv
// Combinational SLICE_W-bit subtractor with borrow in/out; shared by every
// CALC cycle of the sequential subtractor.
module sub_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               borrow_in,
    output logic [SLICE_W-1:0] d,
    output logic               borrow_out
);

    logic [SLICE_W:0] full_s;

    // One extra bit catches the borrow: a negative result sets the top bit.
    always_comb begin
        full_s     = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, borrow_in};
        d          = full_s[SLICE_W-1:0];
        borrow_out = full_s[SLICE_W];
    end

endmodule

// File: rtl/sub_16_bit_seq.sv
// Sequential 16-bit subtractor: one SLICE_W-bit slice per cycle, LSB slice
// first, with valid/ready handshakes on the operand and result sides.
module sub_16_bit_seq
    import sub_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] diff,
    output logic              borrow,
    output logic              ovf,
    output logic              zero,
    output logic              neg
);

    localparam int               N        = DATA_W / SLICE_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r,     state_nx_s;
    logic [DATA_W-1:0] a_sh_r,      a_sh_nx_s;
    logic [DATA_W-1:0] b_sh_r,      b_sh_nx_s;
    logic [DATA_W-1:0] diff_r,      diff_nx_s;
    logic              a_msb_r,     a_msb_nx_s;
    logic              b_msb_r,     b_msb_nx_s;
    logic [CNT_W-1:0]  cnt_r,       cnt_nx_s;
    logic              bchain_r,    bchain_nx_s;
    logic              borrow_r,    borrow_nx_s;
    logic              ovf_r,       ovf_nx_s;
    logic              zero_r,      zero_nx_s;
    logic              neg_r,       neg_nx_s;
    logic              in_ready_r,  in_ready_nx_s;
    logic              out_valid_r, out_valid_nx_s;

    logic [SLICE_W-1:0] slice_d_s;
    logic               slice_bout_s;
    logic [DATA_W-1:0]  diff_ins_s;

    // Operands are shifted right each cycle, so the live slice is always the low bits.
    sub_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a          (a_sh_r[SLICE_W-1:0]),
        .b          (b_sh_r[SLICE_W-1:0]),
        .borrow_in  (bchain_r),
        .d          (slice_d_s),
        .borrow_out (slice_bout_s)
    );

    // Result slices enter at the top and shift down, landing in place after N cycles.
    generate
        if (SLICE_W == DATA_W) begin : g_full
            assign diff_ins_s = slice_d_s;
        end else begin : g_part
            assign diff_ins_s = {slice_d_s, diff_r[DATA_W-1:SLICE_W]};
        end
    endgenerate

    // Next-state, datapath and output-flag computation.
    always_comb begin
        state_nx_s  = state_r;
        a_sh_nx_s   = a_sh_r;
        b_sh_nx_s   = b_sh_r;
        diff_nx_s   = diff_r;
        a_msb_nx_s  = a_msb_r;
        b_msb_nx_s  = b_msb_r;
        cnt_nx_s    = cnt_r;
        bchain_nx_s = bchain_r;
        borrow_nx_s = borrow_r;
        ovf_nx_s    = ovf_r;
        zero_nx_s   = zero_r;
        neg_nx_s    = neg_r;

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    a_sh_nx_s   = a;
                    b_sh_nx_s   = b;
                    a_msb_nx_s  = a[DATA_W-1];
                    b_msb_nx_s  = b[DATA_W-1];
                    cnt_nx_s    = {CNT_W{1'b0}};
                    bchain_nx_s = 1'b0;
                    borrow_nx_s = 1'b0;
                    ovf_nx_s    = 1'b0;
                    zero_nx_s   = 1'b0;
                    neg_nx_s    = 1'b0;
                    state_nx_s  = CALC;
                end else begin
                    state_nx_s  = IDLE;
                end
            end
            CALC: begin
                a_sh_nx_s   = a_sh_r >> SLICE_W;
                b_sh_nx_s   = b_sh_r >> SLICE_W;
                diff_nx_s   = diff_ins_s;
                bchain_nx_s = slice_bout_s;
                if (cnt_r == LAST_CNT) begin
                    borrow_nx_s = slice_bout_s;
                    ovf_nx_s    = sub_ovf(a_msb_r, b_msb_r, diff_ins_s[DATA_W-1]);
                    zero_nx_s   = (diff_ins_s == {DATA_W{1'b0}});
                    neg_nx_s    = diff_ins_s[DATA_W-1];
                    state_nx_s  = DONE;
                end else begin
                    cnt_nx_s    = cnt_r + CNT_ONE;
                    state_nx_s  = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase

        in_ready_nx_s  = (state_nx_s == IDLE);
        out_valid_nx_s = (state_nx_s == DONE);
    end

    // State and registered outputs; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            a_sh_r      <= {DATA_W{1'b0}};
            b_sh_r      <= {DATA_W{1'b0}};
            diff_r      <= {DATA_W{1'b0}};
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            bchain_r    <= 1'b0;
            borrow_r    <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            a_sh_r      <= a_sh_nx_s;
            b_sh_r      <= b_sh_nx_s;
            diff_r      <= diff_nx_s;
            a_msb_r     <= a_msb_nx_s;
            b_msb_r     <= b_msb_nx_s;
            cnt_r       <= cnt_nx_s;
            bchain_r    <= bchain_nx_s;
            borrow_r    <= borrow_nx_s;
            ovf_r       <= ovf_nx_s;
            zero_r      <= zero_nx_s;
            neg_r       <= neg_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign diff      = diff_r;
    assign borrow    = borrow_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
    assign neg       = neg_r;

endmodule

// File: tb/tb_sub_16_bit_seq.sv
// Scoreboard bench for sub_16_bit_seq: main instance at SLICE_W=4 plus
// SLICE_W=1 and SLICE_W=16 instances for the width extremes.
module tb_sub_16_bit_seq;

    typedef struct packed {
        logic [15:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    logic        clk;
    logic        rst_s;
    logic        in_valid_s;
    logic        in_ready_s;
    logic [15:0] a_s;
    logic [15:0] b_s;
    logic        out_valid_s;
    logic        out_ready_s;
    logic [15:0] diff_s;
    logic        borrow_s, ovf_s, zero_s, neg_s;

    logic        iv1_s, ir1_s, ov1_s, bo1_s, of1_s, z1_s, n1_s;
    logic [15:0] d1_s;
    logic        iv16_s, ir16_s, ov16_s, bo16_s, of16_s, z16_s, n16_s;
    logic [15:0] d16_s;

    int   checks;
    int   errors;
    exp_t sb[$];

    sub_16_bit_seq #(.SLICE_W(4)) dut (
        .clk(clk), .rst(rst_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .a(a_s), .b(b_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .diff(diff_s), .borrow(borrow_s), .ovf(ovf_s), .zero(zero_s), .neg(neg_s)
    );

    sub_16_bit_seq #(.SLICE_W(1)) dut_w1 (
        .clk(clk), .rst(rst_s), .in_valid(iv1_s), .in_ready(ir1_s),
        .a(a_s), .b(b_s), .out_valid(ov1_s), .out_ready(1'b1),
        .diff(d1_s), .borrow(bo1_s), .ovf(of1_s), .zero(z1_s), .neg(n1_s)
    );

    sub_16_bit_seq #(.SLICE_W(16)) dut_w16 (
        .clk(clk), .rst(rst_s), .in_valid(iv16_s), .in_ready(ir16_s),
        .a(a_s), .b(b_s), .out_valid(ov16_s), .out_ready(1'b1),
        .diff(d16_s), .borrow(bo16_s), .ovf(of16_s), .zero(z16_s), .neg(n16_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
        logic [16:0] t;
        exp_t        e;
        t        = {1'b0, av} - {1'b0, bv};
        e.diff   = t[15:0];
        e.borrow = t[16];
        e.ovf    = (av[15] != bv[15]) && (t[15] != av[15]);
        e.zero   = (t[15:0] == 16'h0000);
        e.neg    = t[15];
        return e;
    endfunction

    // Inputs change and outputs are read 2 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Result checker: pops the scoreboard on each handshake, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_s && out_valid_s && out_ready_s) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_result", 32'(out_valid_s), 32'(1'b0));
            end else begin
                e = sb.pop_front();
                check_eq("diff",   32'(diff_s),   32'(e.diff));
                check_eq("borrow", 32'(borrow_s), 32'(e.borrow));
                check_eq("ovf",    32'(ovf_s),    32'(e.ovf));
                check_eq("zero",   32'(zero_s),   32'(e.zero));
                check_eq("neg",    32'(neg_s),    32'(e.neg));
            end
        end
    end

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input exp_t e, input int hold);
        int n;
        n = 0;
        while (!in_ready_s && n < 100) begin
            step();
            n++;
        end
        check_eq("in_ready_idle", 32'(in_ready_s), 32'(1'b1));
        a_s        = av;
        b_s        = bv;
        in_valid_s = 1'b1;
        out_ready_s = 1'b0;
        step();
        sb.push_back(e);
        check_eq("in_ready_calc", 32'(in_ready_s), 32'(1'b0));
        // Operand noise while busy must not reach the result.
        n = 0;
        while (!out_valid_s && n < 50) begin
            a_s = 16'($urandom);
            b_s = 16'($urandom);
            step();
            n++;
        end
        check_eq("latency", 32'(n), 32'd4);
        for (int i = 0; i < hold; i++) begin
            a_s = 16'($urandom);
            b_s = 16'($urandom);
            check_eq("hold_diff",     32'(diff_s),      32'(e.diff));
            check_eq("hold_borrow",   32'(borrow_s),    32'(e.borrow));
            check_eq("hold_in_ready", 32'(in_ready_s),  32'(1'b0));
            check_eq("hold_valid",    32'(out_valid_s), 32'(1'b1));
            step();
        end
        in_valid_s  = 1'b0;
        out_ready_s = 1'b1;
        step();
        out_ready_s = 1'b0;
        check_eq("post_consume_valid", 32'(out_valid_s), 32'(1'b0));
        check_eq("post_consume_ready", 32'(in_ready_s),  32'(1'b1));
    endtask

    initial begin
        int          n;
        int          lat1, lat16;
        logic [15:0] av, bv;
        logic [15:0] dd1, dd16;
        logic        zz1, zz16;

        checks = 0;
        errors = 0;
        rst_s = 1'b1; in_valid_s = 1'b0; out_ready_s = 1'b0;
        iv1_s = 1'b0; iv16_s = 1'b0; a_s = 16'h0000; b_s = 16'h0000;
        repeat (3) step();
        check_eq("rst_in_ready",  32'(in_ready_s),  32'(1'b1));
        check_eq("rst_out_valid", 32'(out_valid_s), 32'(1'b0));
        check_eq("rst_outputs",   32'({diff_s, borrow_s, ovf_s, zero_s, neg_s}), 32'd0);
        rst_s = 1'b0;
        step();

        run_op(16'h0005, 16'h0003, {16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}, 3);
        run_op(16'h0003, 16'h0005, {16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1}, 0);
        run_op(16'h8000, 16'h0001, {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}, 1);
        run_op(16'h7FFF, 16'hFFFF, {16'h8000, 1'b1, 1'b1, 1'b0, 1'b1}, 0);
        run_op(16'h1234, 16'h1234, {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}, 2);
        for (int i = 0; i < 6; i++) begin
            av = 16'($urandom);
            bv = (i == 0) ? av : 16'($urandom);
            run_op(av, bv, model(av, bv), i % 3);
        end

        // Reset in the second CALC cycle discards the operation.
        a_s = 16'h4321; b_s = 16'h1111; in_valid_s = 1'b1;
        step();
        in_valid_s = 1'b0;
        step();
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        check_eq("mid_rst_in_ready",  32'(in_ready_s),  32'(1'b1));
        check_eq("mid_rst_out_valid", 32'(out_valid_s), 32'(1'b0));
        check_eq("mid_rst_outputs",   32'({diff_s, borrow_s, ovf_s, zero_s, neg_s}), 32'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid_s) n++;
            step();
        end
        check_eq("no_valid_after_rst", 32'(n), 32'd0);
        run_op(16'h0010, 16'h0001, {16'h000F, 1'b0, 1'b0, 1'b0, 1'b0}, 0);

        // Width extremes: 16 slices of 1 bit, one slice of 16 bits.
        check_eq("w1_ready",  32'(ir1_s),  32'(1'b1));
        check_eq("w16_ready", 32'(ir16_s), 32'(1'b1));
        a_s = 16'h1234; b_s = 16'h1234; iv1_s = 1'b1; iv16_s = 1'b1;
        step();
        iv1_s = 1'b0; iv16_s = 1'b0;
        lat1 = -1; lat16 = -1;
        dd1 = 16'hDEAD; dd16 = 16'hDEAD; zz1 = 1'b0; zz16 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ov1_s && lat1 < 0) begin
                lat1 = k; dd1 = d1_s; zz1 = z1_s;
            end
            if (ov16_s && lat16 < 0) begin
                lat16 = k; dd16 = d16_s; zz16 = z16_s;
            end
            step();
        end
        check_eq("w1_latency",  32'(lat1),  32'd16);
        check_eq("w1_diff",     32'(dd1),   32'h0000);
        check_eq("w1_zero",     32'(zz1),   32'(1'b1));
        check_eq("w16_latency", 32'(lat16), 32'd1);
        check_eq("w16_diff",    32'(dd16),  32'h0000);
        check_eq("w16_zero",    32'(zz16),  32'(1'b1));

        a_s = 16'h0003; b_s = 16'h0005; iv1_s = 1'b1; iv16_s = 1'b1;
        step();
        iv1_s = 1'b0; iv16_s = 1'b0;
        lat1 = -1; lat16 = -1;
        for (int k = 0; k < 40; k++) begin
            if (ov1_s && lat1 < 0) begin
                lat1 = k;
                check_eq("w1_diff2",   32'(d1_s),  32'h0000FFFE);
                check_eq("w1_borrow2", 32'(bo1_s), 32'(1'b1));
            end
            if (ov16_s && lat16 < 0) begin
                lat16 = k;
                check_eq("w16_diff2",   32'(d16_s),  32'h0000FFFE);
                check_eq("w16_borrow2", 32'(bo16_s), 32'(1'b1));
            end
            step();
        end
        check_eq("w1_latency2",  32'(lat1),  32'd16);
        check_eq("w16_latency2", 32'(lat16), 32'd1);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_16_bit_seq.md
SUB_16_BIT_SEQ -- requirements
Module: sub_16_bit_seq

Interface
REQ-001 Parameter SLICE_W, default 4: bits processed per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Derived constant N = 16/SLICE_W: calculation cycles per operation (4 at default).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  operands a, b present.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a  in  16  minuend, unsigned or two's complement.
REQ-008 b  in  16  subtrahend, same encoding as a.
REQ-009 out_valid  out  1  result and flags valid.
REQ-010 out_ready  in  1  consumer takes result.
REQ-011 diff  out  16  a - b modulo 2^16.
REQ-012 borrow  out  1  unsigned a < b.
REQ-013 ovf  out  1  signed overflow.
REQ-014 zero  out  1  diff == 0.
REQ-015 neg  out  1  diff[15].

Function
REQ-016 FSM states IDLE, CALC, DONE SHALL be used; no other reachable states.
REQ-017 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge SHALL capture a, b, clear slice counter and borrow chain, go to CALC.
REQ-018 CALC: in_ready=0; each cycle SHALL compute slice k (bits k*SLICE_W+SLICE_W-1 .. k*SLICE_W) as a_k - b_k - borrow_in, store slice into diff register, propagate borrow_out to next slice.
REQ-019 CALC SHALL last exactly N cycles; after slice N-1 go to DONE.
REQ-020 Latency: operands accepted at edge T SHALL give out_valid=1 starting after edge T+N.
REQ-021 DONE: out_valid=1, in_ready=0; diff and all flags SHALL stay stable until out_ready=1 at an edge, then go to IDLE.
REQ-022 No new operand accepted in the cycle the result is consumed; next accept earliest one cycle later.
REQ-023 in_valid while in_ready=0 SHALL be ignored; a, b changes during CALC/DONE SHALL not affect the result.
REQ-024 borrow = final borrow out of slice N-1.
REQ-025 ovf = (a[15] != b[15]) AND (diff[15] != a[15]), using captured operands.
REQ-026 zero and neg SHALL be derived from the complete diff and valid only with out_valid.
REQ-027 diff/flags outside DONE are don't-care for consumers but SHALL not be X.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, in_ready=1, out_valid=0, diff=0, borrow=ovf=zero=neg=0, counter=0, regardless of state.
REQ-029 rst during CALC or DONE SHALL discard the operation; no out_valid for it afterwards.
REQ-030 rst has priority over in_valid and out_ready in the same cycle.

Structure
REQ-031 Shared package sub_pkg SHALL hold DATA_W=16, state encoding IDLE/CALC/DONE, slice-count width.
REQ-032 One sub-module sub_slice (SLICE_W-bit subtractor: a, b, borrow_in -> d, borrow_out, combinational) SHALL be instantiated once and reused each CALC cycle.

Verification
REQ-033 a=0x0005, b=0x0003 -> diff=0x0002, borrow=0, ovf=0, zero=0, neg=0; out_valid exactly 4 cycles after accept (SLICE_W=4).
REQ-034 a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, ovf=0, neg=1, zero=0.
REQ-035 a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, borrow=0, neg=0; a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, borrow=1.
REQ-036 a=0x1234, b=0x1234 -> diff=0x0000, zero=1; repeat with SLICE_W=1 (16 cycles) and 16 (1 cycle).
REQ-037 out_ready held 0 for 3 cycles in DONE while in_valid=1 with new operands -> diff/flags unchanged, in_ready=0, no capture; out_ready=1 -> IDLE next cycle.
REQ-038 rst=1 during 2nd CALC cycle -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; following operation 0x0010-0x0001 -> 0x000F.
